// File: rtl/elevator_ctrl_nfloor.sv
// Parametrised N-floor elevator controller with latched requests and SCAN
// (collective) scheduling. The car keeps travelling in its current direction
// while requests lie ahead and reverses only from IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        request pulses, bit i = floor i
//   door_hold  keeps the door open (timer reload) while high in DOOR
//   floor      current / last-passed floor
//   dir        1 = up, 0 = down (travel / preferred direction)
//   moving     high while travelling
//   door_open  high while the door is open
//   arrive     one-cycle pulse on the first DOOR cycle after a travel stop
//   pending    latched outstanding requests
module elevator_ctrl_nfloor #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6,
  localparam int unsigned FLOOR_W      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state, state_n;
  logic [FLOOR_W-1:0]    floor_n, next_floor;
  logic                  dir_n, arrive_n;
  logic [TCNT_W-1:0]     tcnt, tcnt_n;
  logic [DCNT_W-1:0]     dcnt, dcnt_n;
  logic [NUM_FLOORS-1:0] eff, clr, cur_oh, next_oh;
  logic                  above, below;

  // Request view, one-hot floor masks and SCAN look-ahead
  always_comb begin
    eff        = pending | req;
    cur_oh     = NUM_FLOORS'(1) << floor;
    next_floor = dir ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    next_oh    = NUM_FLOORS'(1) << next_floor;
    // bits strictly above / strictly below the current floor
    above      = |(eff & ~((NUM_FLOORS'(2) << floor) - NUM_FLOORS'(1)));
    below      = |(eff & (cur_oh - NUM_FLOORS'(1)));
  end

  // Next-state, floor, direction and counter logic
  always_comb begin
    state_n  = state;
    floor_n  = floor;
    dir_n    = dir;
    tcnt_n   = tcnt;
    dcnt_n   = dcnt;
    clr      = '0;
    arrive_n = 1'b0;
    case (state)
      IDLE: begin
        if (|(eff & cur_oh)) begin
          state_n = DOOR;
          dcnt_n  = '0;
          clr     = cur_oh;
        end else if (dir) begin
          if (above) begin
            state_n = MOVE;
            tcnt_n  = '0;
          end else if (below) begin
            state_n = MOVE;
            tcnt_n  = '0;
            dir_n   = 1'b0;
          end
        end else begin
          if (below) begin
            state_n = MOVE;
            tcnt_n  = '0;
          end else if (above) begin
            state_n = MOVE;
            tcnt_n  = '0;
            dir_n   = 1'b1;
          end
        end
      end
      MOVE: begin
        if (tcnt == TCNT_W'(TRAVEL_CYCLES - 1)) begin
          floor_n = next_floor;
          tcnt_n  = '0;
          // stop decision looks at the floor being reached this cycle
          if (|(eff & next_oh)) begin
            state_n  = DOOR;
            dcnt_n   = '0;
            clr      = next_oh;
            arrive_n = 1'b1;
          end
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
      end
      DOOR: begin
        clr = cur_oh;
        if (door_hold || |(req & cur_oh)) begin
          dcnt_n = '0;
        end else if (dcnt == DCNT_W'(DOOR_CYCLES - 1)) begin
          state_n = IDLE;
          dcnt_n  = '0;
          clr     = '0;
        end else begin
          dcnt_n = dcnt + DCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      floor     <= '0;
      dir       <= 1'b1;
      tcnt      <= '0;
      dcnt      <= '0;
      pending   <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else begin
      state     <= state_n;
      floor     <= floor_n;
      dir       <= dir_n;
      tcnt      <= tcnt_n;
      dcnt      <= dcnt_n;
      pending   <= eff & ~clr;
      moving    <= (state_n == MOVE);
      door_open <= (state_n == DOOR);
      arrive    <= arrive_n;
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Directed bench for elevator_ctrl_nfloor with default parameters
// (8 floors, 4 cycles per floor, 6 door cycles).
module tb_elevator_ctrl_nfloor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       door_hold;
  logic [2:0] floor;
  logic       dir, moving, door_open, arrive;
  logic [7:0] pending;

  int total = 0;
  int bad   = 0;

  elevator_ctrl_nfloor dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .door_hold (door_hold),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tick until arrive is seen, bounded
  task automatic wait_arrive(input string tag);
    int n = 0;
    while (arrive !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(arrive), 32'd1);
  endtask

  // tick until the car is idle (door closed, not moving), bounded
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((door_open !== 1'b0 || moving !== 1'b0) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(door_open | moving), 32'd0);
  endtask

  task automatic pulse(input logic [7:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req       = '1;
    door_hold = 1'b0;

    // 1. reset with all requests asserted
    tick();
    tick();
    rst = 1'b0;
    req = '0;
    tick();
    chk("rst_floor",   32'(floor),     32'd0);
    chk("rst_dir",     32'(dir),       32'd1);
    chk("rst_moving",  32'(moving),    32'd0);
    chk("rst_door",    32'(door_open), 32'd0);
    chk("rst_arrive",  32'(arrive),    32'd0);
    chk("rst_pending", 32'(pending),   32'd0);

    // 2. request floor 3 from idle at floor 0
    pulse(8'b0000_1000);
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("t2_moving_c%0d", c), 32'(moving),    32'((c >= 1 && c <= 12) ? 1 : 0));
      chk($sformatf("t2_door_c%0d", c),   32'(door_open), 32'((c >= 13 && c <= 18) ? 1 : 0));
      chk($sformatf("t2_arrive_c%0d", c), 32'(arrive),    32'((c == 13) ? 1 : 0));
      chk($sformatf("t2_floor_c%0d", c),  32'(floor),
          32'((c < 5) ? 0 : (c < 9) ? 1 : (c < 13) ? 2 : 3));
      if (c < 19) tick();
    end
    chk("t2_pending_end", 32'(pending), 32'd0);

    // move down to floor 2 (dir becomes 0)
    pulse(8'b0000_0100);
    wait_arrive("t4_arr2_timeout");
    chk("t4_arr2_floor", 32'(floor), 32'd2);
    chk("t4_arr2_dir",   32'(dir),   32'd0);
    wait_idle("t4_idle2_timeout");

    // 4a/4b. same-floor request, then re-request during door cycle 4
    pulse(8'b0000_0100);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("t4_door_c%0d", c),   32'(door_open), 32'((c <= 10) ? 1 : 0));
      chk($sformatf("t4_moving_c%0d", c), 32'(moving),    32'd0);
      chk($sformatf("t4_pend2_c%0d", c),  32'(pending[2]), 32'd0);
      if (c == 4) req = 8'b0000_0100;
      if (c < 11) begin
        tick();
        req = '0;
      end
    end

    // 4c. door_hold for 10 cycles from the first door cycle
    pulse(8'b0000_0100);
    for (int k = 1; k <= 17; k++) begin
      door_hold = (k <= 10);
      chk($sformatf("t4_hold_door_k%0d", k), 32'(door_open), 32'((k <= 16) ? 1 : 0));
      if (k < 17) tick();
    end
    door_hold = 1'b0;
    chk("t4_hold_floor", 32'(floor), 32'd2);

    // 3. SCAN: heading 2 -> 5, requests for 1 and 4 appear behind/ahead
    pulse(8'b0010_0000);
    chk("t3_dir_up",  32'(dir),    32'd1);
    chk("t3_moving",  32'(moving), 32'd1);
    pulse(8'b0001_0010);
    chk("t3_pend_all", 32'(pending), 32'h32);
    wait_arrive("t3_arr4_timeout");
    chk("t3_arr4_floor", 32'(floor),   32'd4);
    chk("t3_arr4_pend",  32'(pending), 32'h22);
    wait_idle("t3_idle4_timeout");
    wait_arrive("t3_arr5_timeout");
    chk("t3_arr5_floor", 32'(floor),   32'd5);
    chk("t3_arr5_pend",  32'(pending), 32'h02);
    chk("t3_arr5_dir",   32'(dir),     32'd1);
    wait_idle("t3_idle5_timeout");
    wait_arrive("t3_arr1_timeout");
    chk("t3_arr1_floor", 32'(floor),   32'd1);
    chk("t3_arr1_dir",   32'(dir),     32'd0);
    chk("t3_arr1_pend",  32'(pending), 32'h00);
    wait_idle("t3_idle1_timeout");

    // 5a. idle at 4 with dir=1: up to 7 first
    pulse(8'b0001_0000);
    wait_arrive("t5_arr4_timeout");
    chk("t5_arr4_floor", 32'(floor), 32'd4);
    wait_idle("t5_idle4_timeout");
    chk("t5_pre_dir", 32'(dir), 32'd1);
    pulse(8'b1000_0001);
    wait_arrive("t5_up7_timeout");
    chk("t5_up7_floor", 32'(floor), 32'd7);
    wait_idle("t5_idle7_timeout");
    wait_arrive("t5_dn0_timeout");
    chk("t5_dn0_floor", 32'(floor), 32'd0);
    wait_idle("t5_idle0_timeout");

    // 5b. reach floor 4 from above so dir=0, then 0 goes first
    pulse(8'b1000_0000);
    wait_arrive("t5_go7_timeout");
    chk("t5_go7_floor", 32'(floor), 32'd7);
    wait_idle("t5_idle7b_timeout");
    pulse(8'b0001_0000);
    wait_arrive("t5_go4_timeout");
    chk("t5_go4_floor", 32'(floor), 32'd4);
    wait_idle("t5_idle4b_timeout");
    chk("t5_pre_dir0", 32'(dir), 32'd0);
    pulse(8'b1000_0001);
    wait_arrive("t5_first0_timeout");
    chk("t5_first0_floor", 32'(floor), 32'd0);
    wait_idle("t5_idle0b_timeout");
    wait_arrive("t5_then7_timeout");
    chk("t5_then7_floor", 32'(floor), 32'd7);
    wait_idle("t5_idle7c_timeout");

    // 6. reset while travelling between floors 3 and 4
    pulse(8'b0000_0001);
    wait_arrive("t6_go0_timeout");
    chk("t6_go0_floor", 32'(floor), 32'd0);
    wait_idle("t6_idle0_timeout");
    pulse(8'b0110_0000);
    n = 0;
    while (floor !== 3'd3 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_reach3", 32'(floor), 32'd3);
    tick();
    tick();
    chk("t6_pre_moving",  32'(moving),  32'd1);
    chk("t6_pre_pending", 32'(pending), 32'h60);
    rst = 1'b1;
    tick();
    chk("t6_floor",   32'(floor),     32'd0);
    chk("t6_moving",  32'(moving),    32'd0);
    chk("t6_door",    32'(door_open), 32'd0);
    chk("t6_pending", 32'(pending),   32'd0);
    chk("t6_dir",     32'(dir),       32'd1);
    chk("t6_arrive",  32'(arrive),    32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t6_post_arrive_%0d", c), 32'(arrive), 32'd0);
      chk($sformatf("t6_post_moving_%0d", c), 32'(moving), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
